mem_stage: RTL and testbench

//  Memory-access pipeline stage; sits after the execute stage and consumes its ALU address and byte mask.

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/mem_stage_load_align.sv | 31 +++
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, funct3 codes and byte-lane helpers for the memory stage.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      BUS  = 1'b1
   } state_e;

   // Copy one byte onto all four lanes.
   function automatic logic [31:0] rep_byte(input logic [7:0] b);
      return {4{b}};
   endfunction

   // Copy one halfword onto both halfword lanes.
   function automatic logic [31:0] rep_half(input logic [15:0] h);
      return {2{h}};
   endfunction

   // Store data placed so that every lane the strobes may select carries it.
   function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] d);
      logic [31:0] r;
      case (funct3[1:0])
         2'b00:   r = rep_byte(d[7:0]);
         2'b01:   r = rep_half(d[15:0]);
         default: r = d;
      endcase
      return r;
   endfunction

   // Halfword on an odd byte, or word not on a word boundary.
   function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
      logic r;
      case (funct3[1:0])
         2'b01:   r = lo[0];
         2'b10:   r = (lo != 2'b00);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane pick followed by extension chosen by funct3; odd-halfword addresses fall back to addr[1].
   always_comb begin
      byte_v = rdata[{addr_lo, 3'b000} +: 8];
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         FUNCT3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
         FUNCT3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
         FUNCT3_LH:  data = {{(XLEN-16){half_v[15]}}, half_v};
         FUNCT3_LHU: data = {{(XLEN-16){1'b0}}, half_v};
         default:    data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory request at a time, forwards ALU results. Optional MEM_MISALIGN_TRAP_EN.
// Latency: ALU ops 1 cycle; loads/stores 2 cycles plus any dmem_ready wait states.
// Backpressure: stall holds EX from acceptance of a memory op until dmem_ready; stall is 0 during rst.
module mem_stage
   import mem_pkg::*;
#(
   parameter int XLEN   = mem_pkg::XLEN,
   parameter int REG_AW = mem_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [XLEN-1:0]   ex_alu,
   input  logic [3:0]        ex_mask,
   input  logic [XLEN-1:0]   ex_rd2,
   input  logic              ex_load,
   input  logic              ex_store,
   input  logic [2:0]        ex_funct3,
   input  logic              ex_we,
   input  logic [REG_AW-1:0] ex_wa,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [3:0]        dmem_wstrb,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_ready,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_wa,
   output logic [XLEN-1:0]   wb_wd,
   output logic              misalign
);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              is_load_q, is_load_d;
   logic              we_q, we_d;
   logic [REG_AW-1:0] wa_q, wa_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_we_q, wb_we_d;
   logic [REG_AW-1:0] wb_wa_q, wb_wa_d;
   logic [XLEN-1:0]   wb_wd_q, wb_wd_d;
   logic              stall_c;
   logic              mis_now;
   logic              mem_op;
   logic [XLEN-1:0]   ld_data;
`ifdef MEM_MISALIGN_TRAP_EN
   logic              misalign_q, misalign_d;
`endif

   assign mem_op = ex_load | ex_store;

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis_now = access_misaligned(ex_funct3, ex_alu[1:0]);
`else
   assign mis_now = 1'b0;
`endif

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (addr_q[1:0]),
      .funct3  (funct3_q),
      .data    (ld_data)
   );

   // Next-state, operand latch and writeback-record computation.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      funct3_d   = funct3_q;
      is_load_d  = is_load_q;
      we_d       = we_q;
      wa_d       = wa_q;
      wb_valid_d = 1'b0;
      wb_we_d    = wb_we_q;
      wb_wa_d    = wb_wa_q;
      wb_wd_d    = wb_wd_q;
      stall_c    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (!mem_op) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = ex_we;
                  wb_wa_d    = ex_wa;
                  wb_wd_d    = ex_alu;
               end else if (mis_now) begin
                  // Trapped access: retire immediately without touching the bus.
                  wb_valid_d = 1'b1;
                  wb_we_d    = 1'b0;
                  wb_wa_d    = ex_wa;
`ifdef MEM_MISALIGN_TRAP_EN
                  misalign_d = 1'b1;
`endif
               end else begin
                  // Load wins when both load and store are asserted.
                  stall_c   = 1'b1;
                  state_d   = BUS;
                  addr_d    = ex_alu;
                  is_load_d = ex_load;
                  funct3_d  = ex_funct3;
                  we_d      = ex_we;
                  wa_d      = ex_wa;
                  wstrb_d   = ex_load ? 4'b0000 : ex_mask;
                  wdata_d   = store_lanes(ex_funct3, ex_rd2);
               end
            end
         end
         BUS: begin
            stall_c = ~dmem_ready;
            if (dmem_ready) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_wa_d    = wa_q;
               if (is_load_q) begin
                  wb_we_d = we_q;
                  wb_wd_d = ld_data;
               end else begin
                  wb_we_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         funct3_q   <= '0;
         is_load_q  <= 1'b0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_wa_q    <= '0;
         wb_wd_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         funct3_q   <= funct3_d;
         is_load_q  <= is_load_d;
         we_q       <= we_d;
         wa_q       <= wa_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_wa_q    <= wb_wa_d;
         wb_wd_q    <= wb_wd_d;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign stall      = stall_c & ~rst;
   assign dmem_req   = (state_q == BUS);
   assign dmem_we    = dmem_req & ~is_load_q;
   assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign dmem_wstrb = dmem_req ? wstrb_q : 4'b0000;
   assign dmem_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_we      = wb_we_q;
   assign wb_wa      = wb_wa_q;
   assign wb_wd      = wb_wd_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign   = misalign_q;
`else
   assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed table, reset corner cases, randomized ops against a reference model.
// Latency: n/a.
// Backpressure: the bench plays the data memory, inserting dmem_ready wait states.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_load, ex_store, ex_we;
   logic [31:0] ex_alu, ex_rd2;
   logic [3:0]  ex_mask;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_wa;
   logic        stall, dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        wb_valid, wb_we, misalign;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;

   int checks = 0;
   int errors = 0;
   int wb_cnt = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_mask(ex_mask),
      .ex_rd2(ex_rd2), .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
      .ex_we(ex_we), .ex_wa(ex_wa), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_wa(wb_wa), .wb_wd(wb_wd), .misalign(misalign)
   );

   // Count writeback pulses in the middle of each cycle.
   always @(negedge clk) if (wb_valid) wb_cnt <= wb_cnt + 1;

   typedef struct {
      logic        load, store, we;
      logic [2:0]  f3;
      logic [31:0] alu, rd2;
      logic [3:0]  mask;
      logic [4:0]  wa;
   } op_t;

   typedef struct {
      int          stall_cyc, req_cyc, pulses;
      logic [31:0] addr, wdata, wd, wd_after;
      logic [3:0]  wstrb;
      logic        dwe, wb_we, mis, valid, valid_after;
      logic [4:0]  wa;
   } obs_t;

   typedef struct {
      op_t         op;
      int          waits;
      logic [31:0] rdata, exp_wd, exp_wdata;
      logic        exp_we, exp_dwe;
      logic [3:0]  exp_wstrb;
      int          exp_stall, exp_req;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic op_t mkop(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rd2,
                                input logic [3:0] mask, input logic we, input logic [4:0] wa);
      op_t o;
      o.load = ld; o.store = st; o.f3 = f3; o.alu = alu; o.rd2 = rd2;
      o.mask = mask; o.we = we; o.wa = wa;
      return o;
   endfunction

   // Presents one op (called at posedge+1), plays memory, returns what was observed.
   task automatic run_op(input op_t op, input int waits, input logic [31:0] rdata, output obs_t o);
      int  cyc;
      int  p0;
      bit  done;
      o = '{default: 0};
      p0 = wb_cnt;
      ex_valid = 1'b1; ex_load = op.load; ex_store = op.store; ex_funct3 = op.f3;
      ex_alu = op.alu; ex_rd2 = op.rd2; ex_mask = op.mask; ex_we = op.we; ex_wa = op.wa;
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 64) begin
         #1;
         if (dmem_req) begin
            o.addr = dmem_addr; o.wdata = dmem_wdata; o.wstrb = dmem_wstrb; o.dwe = dmem_we;
            dmem_ready = (o.req_cyc >= waits);
            dmem_rdata = rdata;
            o.req_cyc++;
         end else begin
            dmem_ready = 1'b0;
         end
         #1;
         if (stall) o.stall_cyc++;
         else done = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) chk("op_timeout", 32'd1, 32'd0);
      ex_valid = 1'b0; dmem_ready = 1'b0;
      o.valid = wb_valid; o.wb_we = wb_we; o.wa = wb_wa; o.wd = wb_wd; o.mis = misalign;
      @(posedge clk); #1;
      o.valid_after = wb_valid; o.wd_after = wb_wd;
      o.pulses = wb_cnt - p0;
   endtask

   // Reference behaviour derived from the access rules, using shifts and multiplies.
   function automatic obs_t model(input op_t op, input int waits, input logic [31:0] rdata);
      obs_t        e;
      logic [31:0] b, h;
`ifdef MEM_MISALIGN_TRAP_EN
      logic        mis;
`endif
      e = '{default: 0};
      e.valid = 1'b1;
      e.pulses = 1;
      e.wa = op.wa;
      if (!op.load && !op.store) begin
         e.wb_we = op.we; e.wd = op.alu; e.wd_after = op.alu;
         return e;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      mis = (op.f3[1:0] == 2'b01 && op.alu[0]) || (op.f3[1:0] == 2'b10 && op.alu[1:0] != 2'b00);
      if (mis) begin
         e.mis = 1'b1;
         return e;
      end
`endif
      e.stall_cyc = waits + 1;
      e.req_cyc = waits + 1;
      e.addr = op.alu & 32'hFFFF_FFFC;
      e.dwe = !op.load;
      e.wstrb = op.load ? 4'b0000 : op.mask;
      case (op.f3[1:0])
         2'b00:   e.wdata = {24'h0, op.rd2[7:0]} * 32'h0101_0101;
         2'b01:   e.wdata = {16'h0, op.rd2[15:0]} * 32'h0001_0001;
         default: e.wdata = op.rd2;
      endcase
      if (op.load) begin
         e.wb_we = op.we;
         b = (rdata >> (8 * op.alu[1:0])) & 32'hFF;
         h = (rdata >> (16 * op.alu[1])) & 32'hFFFF;
         case (op.f3)
            3'b000:  e.wd = b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b001:  e.wd = h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  e.wd = b;
            3'b101:  e.wd = h;
            default: e.wd = rdata;
         endcase
         e.wd_after = e.wd;
      end
      return e;
   endfunction

   vec_t vecs[12];
   obs_t o, e;
   op_t  rop;
   int   p0;

   initial begin
      vecs[0]  = '{mkop(1,0,3'b010,32'h100,32'h0,4'hF,1,5'd5), 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1, 0, 4'h0, 1, 1};
      vecs[1]  = '{mkop(1,0,3'b000,32'h103,32'h0,4'h8,1,5'd6), 0, 32'h80FF0000, 32'hFFFFFF80, 32'h0, 1, 0, 4'h0, 1, 1};
      vecs[2]  = '{mkop(1,0,3'b100,32'h103,32'h0,4'h8,1,5'd6), 0, 32'h80FF0000, 32'h00000080, 32'h0, 1, 0, 4'h0, 1, 1};
      vecs[3]  = '{mkop(0,1,3'b001,32'h102,32'h1234ABCD,4'b1100,1,5'd9), 0, 32'h0, 32'h0, 32'hABCDABCD, 0, 1, 4'b1100, 1, 1};
      vecs[4]  = '{mkop(1,0,3'b010,32'h200,32'h0,4'hF,1,5'd10), 3, 32'h0BADF00D, 32'h0BADF00D, 32'h0, 1, 0, 4'h0, 4, 4};
      vecs[5]  = '{mkop(0,0,3'b000,32'h55,32'h0,4'h0,1,5'd7), 0, 32'h0, 32'h55, 32'h0, 1, 0, 4'h0, 0, 0};
      vecs[6]  = '{mkop(1,0,3'b001,32'h102,32'h0,4'hC,1,5'd11), 0, 32'h80011234, 32'hFFFF8001, 32'h0, 1, 0, 4'h0, 1, 1};
      vecs[7]  = '{mkop(1,0,3'b101,32'h100,32'h0,4'h3,1,5'd12), 0, 32'h8001F234, 32'h0000F234, 32'h0, 1, 0, 4'h0, 1, 1};
      vecs[8]  = '{mkop(0,1,3'b000,32'h101,32'h000000A5,4'b0010,0,5'd13), 0, 32'h0, 32'h0, 32'hA5A5A5A5, 0, 1, 4'b0010, 1, 1};
      vecs[9]  = '{mkop(1,1,3'b010,32'h300,32'h0,4'hF,1,5'd14), 0, 32'h12345678, 32'h12345678, 32'h0, 1, 0, 4'h0, 1, 1};
      vecs[10] = '{mkop(1,0,3'b000,32'h102,32'h0,4'h4,0,5'd15), 1, 32'h007F0000, 32'h0000007F, 32'h0, 0, 0, 4'h0, 2, 2};
      vecs[11] = '{mkop(0,1,3'b010,32'h204,32'hCAFEBABE,4'hF,1,5'd16), 2, 32'h0, 32'h0, 32'hCAFEBABE, 0, 1, 4'hF, 3, 3};

      // Reset, with a load being offered to prove stall stays low.
      rst = 1'b1; ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_we = 1'b1;
      ex_alu = 32'h100; ex_rd2 = '0; ex_mask = 4'hF; ex_funct3 = 3'b010; ex_wa = 5'd1;
      dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_req", {31'h0, dmem_req}, 32'h0);
      chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("rst_wb_we", {31'h0, wb_we}, 32'h0);
      chk("rst_wb_wd", wb_wd, 32'h0);
      chk("rst_misalign", {31'h0, misalign}, 32'h0);
      ex_valid = 1'b0; rst = 1'b0;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].waits, vecs[i].rdata, o);
         chk($sformatf("v%0d_stall_cycles", i), o.stall_cyc, vecs[i].exp_stall);
         chk($sformatf("v%0d_req_cycles", i), o.req_cyc, vecs[i].exp_req);
         chk($sformatf("v%0d_wb_pulses", i), o.pulses, 32'd1);
         chk($sformatf("v%0d_wb_valid", i), {31'h0, o.valid}, 32'h1);
         chk($sformatf("v%0d_wb_we", i), {31'h0, o.wb_we}, {31'h0, vecs[i].exp_we});
         chk($sformatf("v%0d_wb_wa", i), {27'h0, o.wa}, {27'h0, vecs[i].op.wa});
         chk($sformatf("v%0d_valid_after", i), {31'h0, o.valid_after}, 32'h0);
         if (vecs[i].exp_req > 0) begin
            chk($sformatf("v%0d_addr", i), o.addr, vecs[i].op.alu & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_wstrb", i), {28'h0, o.wstrb}, {28'h0, vecs[i].exp_wstrb});
            chk($sformatf("v%0d_dmem_we", i), {31'h0, o.dwe}, {31'h0, vecs[i].exp_dwe});
         end
         if (vecs[i].exp_dwe) chk($sformatf("v%0d_wdata", i), o.wdata, vecs[i].exp_wdata);
         if (vecs[i].exp_we) begin
            chk($sformatf("v%0d_wb_wd", i), o.wd, vecs[i].exp_wd);
            chk($sformatf("v%0d_wd_hold", i), o.wd_after, vecs[i].exp_wd);
         end
      end

      // Reset while a load waits on the bus: request withdrawn, no writeback.
      p0 = wb_cnt;
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_alu = 32'h400; ex_we = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      chk("rstbus_req_before", {31'h0, dmem_req}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rstbus_stall_in_rst", {31'h0, stall}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstbus_req_after", {31'h0, dmem_req}, 32'h0);
      @(posedge clk); #1;
      chk("rstbus_req_later", {31'h0, dmem_req}, 32'h0);
      chk("rstbus_no_wb", wb_cnt - p0, 32'd0);

      // Misaligned word access.
      run_op(mkop(1,0,3'b010,32'h101,32'h0,4'hF,1,5'd3), 0, 32'h11223344, o);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_flag", {31'h0, o.mis}, 32'h1);
      chk("mis_no_req", o.req_cyc, 32'd0);
      chk("mis_no_stall", o.stall_cyc, 32'd0);
      chk("mis_wb_we", {31'h0, o.wb_we}, 32'h0);
      chk("mis_wb_valid", {31'h0, o.valid}, 32'h1);
      chk("mis_one_cycle", {31'h0, misalign}, 32'h0);
`else
      chk("mis_flag_tied", {31'h0, o.mis}, 32'h0);
      chk("mis_issued", o.req_cyc, 32'd1);
      chk("mis_addr", o.addr, 32'h100);
      chk("mis_wd", o.wd, 32'h11223344);
`endif

      // Randomized ops against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [2:0]  f3;
         logic [31:0] rd;
         int          kind, waits;
         kind = $urandom_range(0, 3);
         case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
         endcase
         if (kind == 2 && f3[2]) f3[2] = 1'b0;
         rop = mkop(kind == 1 || kind == 3, kind == 2 || kind == 3, f3, $urandom, $urandom,
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         waits = $urandom_range(0, 3);
         rd = $urandom;
         run_op(rop, waits, rd, o);
         e = model(rop, waits, rd);
         chk($sformatf("r%0d_stall_cycles", n), o.stall_cyc, e.stall_cyc);
         chk($sformatf("r%0d_req_cycles", n), o.req_cyc, e.req_cyc);
         chk($sformatf("r%0d_wb_pulses", n), o.pulses, e.pulses);
         chk($sformatf("r%0d_wb_valid", n), {31'h0, o.valid}, {31'h0, e.valid});
         chk($sformatf("r%0d_wb_we", n), {31'h0, o.wb_we}, {31'h0, e.wb_we});
         chk($sformatf("r%0d_wb_wa", n), {27'h0, o.wa}, {27'h0, e.wa});
         chk($sformatf("r%0d_misalign", n), {31'h0, o.mis}, {31'h0, e.mis});
         if (e.req_cyc > 0) begin
            chk($sformatf("r%0d_addr", n), o.addr, e.addr);
            chk($sformatf("r%0d_wstrb", n), {28'h0, o.wstrb}, {28'h0, e.wstrb});
            chk($sformatf("r%0d_dmem_we", n), {31'h0, o.dwe}, {31'h0, e.dwe});
            if (e.dwe) chk($sformatf("r%0d_wdata", n), o.wdata, e.wdata);
         end
         if (e.wb_we) chk($sformatf("r%0d_wb_wd", n), o.wd, e.wd);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         #0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
